jtgng_scandbl_buf: RTL and testbench

JTGNG_SCANDBL_BUF -- requirements
Module: jtgng_scandbl_buf

---
 rtl/jtgng_scandbl_buf.sv | 157 +++++++++++++++
 tb/tb_jtgng_scandbl_buf.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/jtgng_scandbl_buf.sv
// Ping-pong line buffer that replays each source line twice at the pxl2_cen rate with its own VGA porches.
// Define JTGNG_SCANDBL_SCANLINE_EN to dim the second copy of every line to half intensity.
module jtgng_scandbl_buf #(
  parameter int COLORW = 4,
  parameter int HLEN   = 512,
  parameter int HFP    = 8,
  parameter int HSW    = 48,
  parameter int HBP    = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pxl_cen,
  input  logic                pxl2_cen,
  input  logic                LHBL,
  input  logic                LVBL,
  input  logic [COLORW*3-1:0] rgb_in,
  output logic [COLORW*3-1:0] rgb_out,
  output logic                double,
  output logic                vga_hs,
  output logic                vga_lhbl
);
  localparam int DW   = COLORW * 3;
  localparam int AW   = $clog2(HLEN);
  localparam int TMAX = (HFP > HSW) ? ((HFP > HBP) ? HFP : HBP) : ((HSW > HBP) ? HSW : HBP);
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [AW-1:0] ADDR_LAST = AW'(HLEN - 1);
  localparam logic [TW-1:0] FP_END    = TW'(HFP - 1);
  localparam logic [TW-1:0] SW_END    = TW'(HSW - 1);
  localparam logic [TW-1:0] BP_END    = TW'(HBP - 1);
`ifdef JTGNG_SCANDBL_SCANLINE_EN
  localparam bit SCANLINE = 1'b1;
`else
  localparam bit SCANLINE = 1'b0;
`endif

  typedef enum logic [2:0] {ACTIVE, FRONT, SYNC, BACK, IDLE} state_t;

  logic [DW-1:0] mem [0:2*HLEN-1];
  state_t        state, state_nx;
  logic [AW-1:0] wr_addr, rd_addr, rd_addr_nx, length;
  logic [TW-1:0] tcnt, tcnt_nx;
  logic          double_nx, bank, blank, lhbl_last, line_end;

  function automatic logic [DW-1:0] shade(input logic [DW-1:0] px, input logic dim);
    logic [DW-1:0] r;
    r = px;
    if (dim && SCANLINE)
      for (int c = 0; c < 3; c++) r[c*COLORW +: COLORW] = px[c*COLORW +: COLORW] >> 1;
    return r;
  endfunction

  assign line_end = pxl_cen & lhbl_last & ~LHBL;

  // write side: bank is the write bank, ~bank is being read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_addr   <= '0;
      length    <= '0;
      bank      <= 1'b0;
      blank     <= 1'b1;
      lhbl_last <= 1'b0;
    end else if (pxl_cen) begin
      lhbl_last <= LHBL;
      if (line_end) begin
        length  <= wr_addr;
        wr_addr <= '0;
        bank    <= ~bank;
        blank   <= ~LVBL;
      end else if (LHBL && wr_addr != ADDR_LAST) begin
        wr_addr <= wr_addr + AW'(1);
      end
    end
  end

  // Saturated writes keep landing on the last location.
  always_ff @(posedge clk) begin
    if (pxl_cen && LHBL) mem[{bank, wr_addr}] <= rgb_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      rd_addr <= '0;
      tcnt    <= '0;
      double  <= 1'b0;
    end else begin
      state   <= state_nx;
      rd_addr <= rd_addr_nx;
      tcnt    <= tcnt_nx;
      double  <= double_nx;
    end
  end

  // A new line always wins over whatever the read side is doing.
  always_comb begin
    state_nx   = state;
    rd_addr_nx = rd_addr;
    tcnt_nx    = tcnt;
    double_nx  = double;
    if (line_end) begin
      state_nx   = (wr_addr == '0) ? FRONT : ACTIVE;
      rd_addr_nx = '0;
      tcnt_nx    = '0;
      double_nx  = 1'b0;
    end else if (pxl2_cen) begin
      case (state)
        ACTIVE: begin
          if (rd_addr == length - AW'(1)) begin
            state_nx = FRONT;
            tcnt_nx  = '0;
          end else begin
            rd_addr_nx = rd_addr + AW'(1);
          end
        end
        FRONT: begin
          if (tcnt == FP_END) begin
            state_nx = SYNC;
            tcnt_nx  = '0;
          end else tcnt_nx = tcnt + TW'(1);
        end
        SYNC: begin
          if (tcnt == SW_END) begin
            state_nx = BACK;
            tcnt_nx  = '0;
          end else tcnt_nx = tcnt + TW'(1);
        end
        BACK: begin
          if (tcnt == BP_END) begin
            tcnt_nx = '0;
            if (!double) begin
              double_nx  = 1'b1;
              rd_addr_nx = '0;
              state_nx   = (length == '0) ? FRONT : ACTIVE;
            end else begin
              state_nx = IDLE;
            end
          end else tcnt_nx = tcnt + TW'(1);
        end
        default: ;
      endcase
    end
  end

  // output stage: one pxl2_cen tick behind the read FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_out  <= '0;
      vga_hs   <= 1'b1;
      vga_lhbl <= 1'b0;
    end else if (pxl2_cen) begin
      vga_lhbl <= (state == ACTIVE);
      vga_hs   <= (state != SYNC);
      if (state == ACTIVE && !blank) rgb_out <= shade(mem[{~bank, rd_addr}], double);
      else                           rgb_out <= '0;
    end
  end
endmodule

// File: tb/tb_jtgng_scandbl_buf.sv
// Randomized bench for jtgng_scandbl_buf: a line-level model predicts every output on every cycle.
module tb_jtgng_scandbl_buf;
  localparam int COLORW = 4;
  localparam int HLEN   = 512;
  localparam int HFP    = 8;
  localparam int HSW    = 48;
  localparam int HBP    = 24;
  localparam int PORCH  = HFP + HSW + HBP;
`ifdef JTGNG_SCANDBL_SCANLINE_EN
  localparam bit SCAN = 1'b1;
`else
  localparam bit SCAN = 1'b0;
`endif

  logic        clk = 1'b0, rst = 1'b1, pxl_cen = 1'b0, pxl2_cen = 1'b0;
  logic        LHBL = 1'b0, LVBL = 1'b1;
  logic [11:0] rgb_in = '0;
  logic [11:0] rgb_out;
  logic        double, vga_hs, vga_lhbl;

  jtgng_scandbl_buf #(.COLORW(COLORW), .HLEN(HLEN), .HFP(HFP), .HSW(HSW), .HBP(HBP)) dut (
    .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .pxl2_cen(pxl2_cen), .LHBL(LHBL), .LVBL(LVBL),
    .rgb_in(rgb_in), .rgb_out(rgb_out), .double(double), .vga_hs(vga_hs), .vga_lhbl(vga_lhbl)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0, cyc = 0;
  bit cen_off = 1'b0;

  // line-level model state
  logic [11:0] wpx [HLEN];
  logic [11:0] cpx [HLEN];
  int  wn = 0, clen = 0, j = 0, cur_id = 0, e_id = 0;
  bit  last = 1'b0, cblank = 1'b0, cvalid = 1'b0;
  logic [11:0] e_rgb = '0;
  bit  e_lb = 1'b0, e_hs = 1'b1, e_dbl = 1'b0;

  int act_cnt [32][2];
  int hs_cnt [32];
  logic [11:0] first_rgb [32][2];
  logic [11:0] ramp [2][256];
  int bad0, bad1;

  function automatic logic [11:0] shade(input logic [11:0] px, input bit dim);
    logic [11:0] h;
    h = {1'b0, px[11:9], 1'b0, px[7:5], 1'b0, px[3:1]};
    return (dim && SCAN) ? h : px;
  endfunction

  // Output expected at tick jj after the line start: L pixels, FP, SYNC, BP, twice, then idle.
  task automatic expect_at(input int jj);
    int k, p;
    e_rgb = '0; e_lb = 1'b0; e_hs = 1'b1;
    if (cvalid && jj < 2 * (clen + PORCH)) begin
      p = jj / (clen + PORCH);
      k = jj % (clen + PORCH);
      if (k < clen) begin
        e_lb  = 1'b1;
        e_rgb = cblank ? 12'h000 : shade(cpx[k], p == 1);
      end else if (k >= clen + HFP && k < clen + HFP + HSW) begin
        e_hs = 1'b0;
      end
    end
  endtask

  task automatic model_reset();
    wn = 0; last = 1'b0; cvalid = 1'b0; j = 0;
    e_rgb = '0; e_lb = 1'b0; e_hs = 1'b1; e_dbl = 1'b0;
  endtask

  task automatic model_tick();
    if (pxl2_cen) begin
      expect_at(j);
      e_id = cur_id;
      j++;
    end
    if (pxl_cen) begin
      if (last && !LHBL) begin
        cpx = wpx; clen = wn; cblank = !LVBL; cvalid = 1'b1;
        j = 0; cur_id++; wn = 0;
      end else if (LHBL && wn < HLEN - 1) begin
        wpx[wn] = rgb_in;
        wn++;
      end
      last = LHBL;
    end
    e_dbl = cvalid && (j >= clen + PORCH);
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic step();
    int p;
    pxl2_cen = !cen_off && (cyc % 2 == 0);
    pxl_cen  = !cen_off && (cyc % 4 == 0);
    @(posedge clk);
    if (rst) model_reset();
    else     model_tick();
    #1;
    n_vec++;
    if (rgb_out !== e_rgb || vga_lhbl !== e_lb || vga_hs !== e_hs || double !== e_dbl) begin
      n_err++;
      $display("FAIL cycle %0d outputs: got rgb=%h lhbl=%b hs=%b dbl=%b, want rgb=%h lhbl=%b hs=%b dbl=%b",
               cyc, rgb_out, vga_lhbl, vga_hs, double, e_rgb, e_lb, e_hs, e_dbl);
    end
    if (!rst && pxl2_cen && e_id < 32) begin
      p = (double === 1'b1) ? 1 : 0;
      if (vga_lhbl === 1'b1) begin
        if (act_cnt[e_id][p] == 0) first_rgb[e_id][p] = rgb_out;
        if (e_id == 1 && act_cnt[1][p] < 256) ramp[p][act_cnt[1][p]] = rgb_out;
        act_cnt[e_id][p]++;
      end
      if (vga_hs === 1'b0) hs_cnt[e_id]++;
    end
    cyc++;
  endtask

  task automatic mid_reset();
    check("pre_rst_active", int'(vga_lhbl), 1);
    cen_off = 1'b1; pxl_cen = 1'b0; pxl2_cen = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_rgb", int'(rgb_out), 0);
    check("rst_lhbl", int'(vga_lhbl), 0);
    check("rst_hs", int'(vga_hs), 1);
    check("rst_dbl", int'(double), 0);
    model_reset();
    step(); step();
    rst = 1'b0;
    step(); step();
    cen_off = 1'b0;
  endtask

  // mode 0: ramp, 1: 0xFFF, 2: random
  task automatic pixels(input int n, input bit vb, input int mode);
    LVBL = vb;
    for (int i = 0; i < n; i++) begin
      LHBL   = 1'b1;
      rgb_in = (mode == 0) ? 12'(i) : (mode == 1) ? 12'hFFF : 12'($urandom);
      repeat (4) step();
    end
  endtask

  task automatic blank_ticks(input int n, input int rst_at);
    for (int i = 0; i < n; i++) begin
      if (i == rst_at) mid_reset();
      LHBL   = 1'b0;
      rgb_in = 12'($urandom);
      repeat (4) step();
    end
  endtask

  initial begin
    int n;
    repeat (4) step();
    check("init_rgb", int'(rgb_out), 0);
    check("init_lhbl", int'(vga_lhbl), 0);
    check("init_hs", int'(vga_hs), 1);
    check("init_dbl", int'(double), 0);
    rst = 1'b0;
    repeat (4) step();

    pixels(256, 1'b1, 0); blank_ticks(100, -1);           // line 1: ramp 0..255
    pixels(256, 1'b0, 2);                                 // line 2: vertically blanked
    check("idle_dbl", int'(double), 1);
    check("idle_lhbl", int'(vga_lhbl), 0);
    check("idle_hs", int'(vga_hs), 1);
    blank_ticks(100, -1);
    check("ramp_act0", act_cnt[1][0], 256);
    check("ramp_act1", act_cnt[1][1], 256);
    check("ramp_sync", hs_cnt[1], 2 * 48);
    bad0 = -1; bad1 = -1;
    for (int k = 0; k < 256; k++) begin
      if (ramp[0][k] !== 12'(k) && bad0 < 0) bad0 = k;
      if (ramp[1][k] !== shade(12'(k), 1'b1) && bad1 < 0) bad1 = k;
    end
    check("ramp_pass0_bad_idx", bad0, -1);
    check("ramp_pass1_bad_idx", bad1, -1);

    pixels(600, 1'b1, 0); blank_ticks(600, -1);           // line 3: overlong
    check("long_act0", act_cnt[3][0], 511);
    check("long_act1", act_cnt[3][1], 511);

    pixels(100, 1'b1, 2); blank_ticks(5, -1);             // line 4: cut short in SYNC
    pixels(60, 1'b1, 2);  blank_ticks(200, 10);           // line 5: reset while active
    check("cut_act0", act_cnt[4][0], 100);
    check("cut_act1", act_cnt[4][1], 0);
    check("cut_sync", hs_cnt[4], 22);

    pixels(8, 1'b1, 1); blank_ticks(120, -1);             // line 6: white
    check("white_act0", act_cnt[6][0], 8);
    check("white_pass0", int'(first_rgb[6][0]), 12'hFFF);
    check("white_pass1", int'(first_rgb[6][1]), SCAN ? 12'h777 : 12'hFFF);

    for (int i = 0; i < 12; i++) begin
      n = $urandom_range(1, 300);
      pixels(n, $urandom_range(0, 3) != 0, 2);
      blank_ticks($urandom_range(1, n + 100), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
